// File: rtl/fc1_kr_ber_mon_if.sv
// ---------------------------------------------------------------------------
// fc1_kr_ber_mon_if
// Bundles the decoder-side block stream and the FC1 CSR bus for one
// fc1_kr_ber_mon channel.
//   PCS side : iPCS_DOUT_BLOCK_SYNC, iPCS_DOUT_SH[1:0], iPCS_DOUT_EN
//   CSR side : iCSR_WR_EN, iCSR_RD_EN, iCSR_ADDR[9:0], iCSR_WR_DATA[63:0],
//              oCSR_RD_DATA[63:0], oCSR_RD_DATA_V
// master = the side driving the PCS/CSR inputs, slave = the monitor.
// ---------------------------------------------------------------------------
interface fc1_kr_ber_mon_if;
    logic        iPCS_DOUT_BLOCK_SYNC;
    logic [1:0]  iPCS_DOUT_SH;
    logic        iPCS_DOUT_EN;
    logic        iCSR_WR_EN;
    logic        iCSR_RD_EN;
    logic [9:0]  iCSR_ADDR;
    logic [63:0] iCSR_WR_DATA;
    logic [63:0] oCSR_RD_DATA;
    logic        oCSR_RD_DATA_V;

    modport master (
        output iPCS_DOUT_BLOCK_SYNC, iPCS_DOUT_SH, iPCS_DOUT_EN,
        output iCSR_WR_EN, iCSR_RD_EN, iCSR_ADDR, iCSR_WR_DATA,
        input  oCSR_RD_DATA, oCSR_RD_DATA_V
    );

    modport slave (
        input  iPCS_DOUT_BLOCK_SYNC, iPCS_DOUT_SH, iPCS_DOUT_EN,
        input  iCSR_WR_EN, iCSR_RD_EN, iCSR_ADDR, iCSR_WR_DATA,
        output oCSR_RD_DATA, oCSR_RD_DATA_V
    );
endinterface

// File: rtl/fc1_kr_ber_mon.sv
// ---------------------------------------------------------------------------
// fc1_kr_ber_mon
// Per-channel 64b/66b BER monitor behind the FC1 KR decoder. Counts invalid
// sync headers (00/11) per time window, raises hi_ber at a programmable
// threshold and keeps saturating statistics readable over the CSR bus.
//
// Ports
//   iCLK_FC_CORE  core clock
//   iRST_FC_CORE  synchronous active-high reset
//   bus           fc1_kr_ber_mon_if.slave (PCS block stream + CSR bus)
//   oHI_BER       high-BER indication (registered)
//   oLINK_GOOD    registered block_sync & ~hi_ber
//
// CSR map (offset from CSR_BASE)
//   0 STATUS [0] hi_ber [1] block_sync [2] sticky hi_ber (W1C) [3] sticky sync loss (W1C)
//   1 BAD_SH_CNT [31:0]   2 HIBER_EVT_CNT [15:0]   3 CONFIG [4:0] threshold
//   4 WINDOW [23:0]  only when FC1_BER_WINDOW_CSR_EN is defined
// ---------------------------------------------------------------------------
module fc1_kr_ber_mon #(
    parameter int unsigned WINDOW_CYCLES = 26562,
    parameter int unsigned HIBER_THRESH  = 16,
    parameter logic [9:0]  CSR_BASE      = 10'h040
) (
    input  logic             iCLK_FC_CORE,
    input  logic             iRST_FC_CORE,
    fc1_kr_ber_mon_if.slave  bus,
    output logic             oHI_BER,
    output logic             oLINK_GOOD
);
    localparam int unsigned TIMER_W = 24;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned BAD_W   = 32;
    localparam int unsigned EVT_W   = 16;
`ifdef FC1_BER_WINDOW_CSR_EN
    localparam int unsigned NUM_REGS = 5;
`else
    localparam int unsigned NUM_REGS = 4;
`endif
    localparam logic [TIMER_W-1:0] WIN_RST = TIMER_W'(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [BAD_W-1:0]   BAD_MAX = '1;
    localparam logic [EVT_W-1:0]   EVT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_HI_BER = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   ber_cnt_q, ber_cnt_d;
    logic               hi_ber_q, hi_ber_d;
    logic               sync_q, sync_d;
    logic               link_good_q, link_good_d;
    logic [CNT_W-1:0]   thresh_q, thresh_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [EVT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic               sticky_hi_q, sticky_hi_d;
    logic               sticky_loss_q, sticky_loss_d;
    logic [63:0]        rd_data_q, rd_data_d;
    logic               rd_v_q, rd_v_d;

    logic               sync_in;
    logic               bad_blk;
    logic [9:0]         addr_off;
    logic               addr_hit;
    logic [NUM_REGS-1:0] wr_sel;
    logic [TIMER_W-1:0] win_cur;
    logic [TIMER_W-1:0] win_lim;
    logic               expire;
    logic               win_start;
    logic [CNT_W-1:0]   cnt_upd;
    logic               thr_hit;
    logic [63:0]        rd_mux;

    // Window length used by the running window; a WINDOW write is only
    // picked up when a new window starts.
`ifdef FC1_BER_WINDOW_CSR_EN
    logic [TIMER_W-1:0] window_q, window_d;
    logic [TIMER_W-1:0] win_act_q, win_act_d;
    assign win_cur = win_act_q;
`else
    logic unused_win_start;
    assign unused_win_start = win_start;
    assign win_cur          = WIN_RST;
`endif

    logic unused_wdata;
    assign unused_wdata = ^bus.iCSR_WR_DATA;

    // Decode and per-window arithmetic
    always_comb begin
        sync_in  = bus.iPCS_DOUT_BLOCK_SYNC;
        bad_blk  = bus.iPCS_DOUT_EN &
                   ((bus.iPCS_DOUT_SH == 2'b00) | (bus.iPCS_DOUT_SH == 2'b11));
        addr_off = bus.iCSR_ADDR - CSR_BASE;
        addr_hit = (addr_off < 10'(NUM_REGS));
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            wr_sel[i] = bus.iCSR_WR_EN & (addr_off == 10'(i));
        end
        win_lim  = (win_cur == '0) ? TIMER_W'(1) : win_cur;
        expire   = (timer_q == win_lim - TIMER_W'(1));
        cnt_upd  = (ber_cnt_q == CNT_MAX) ? ber_cnt_q : ber_cnt_q + CNT_W'(bad_blk);
        thr_hit  = (thresh_q != '0) && (cnt_upd >= thresh_q);
    end

    // BER state machine; loss of block_sync overrides everything
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ber_cnt_d = ber_cnt_q;
        hi_ber_d  = hi_ber_q;
        win_start = 1'b0;
        if (!sync_in) begin
            state_d   = ST_IDLE;
            timer_d   = '0;
            ber_cnt_d = '0;
            hi_ber_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_COUNT;
                    timer_d   = '0;
                    ber_cnt_d = '0;
                    hi_ber_d  = 1'b0;
                    win_start = 1'b1;
                end
                ST_COUNT: begin
                    // A bad block on the expiry cycle still belongs to the ending window.
                    if (thr_hit) begin
                        state_d  = ST_HI_BER;
                        hi_ber_d = 1'b1;
                    end else if (expire) begin
                        hi_ber_d = 1'b0;
                    end
                    if (expire) begin
                        timer_d   = '0;
                        ber_cnt_d = '0;
                        win_start = 1'b1;
                    end else begin
                        timer_d   = timer_q + TIMER_W'(1);
                        ber_cnt_d = cnt_upd;
                    end
                end
                ST_HI_BER: begin
                    hi_ber_d = 1'b1;
                    if (expire) begin
                        state_d   = ST_COUNT;
                        timer_d   = '0;
                        ber_cnt_d = '0;
                        win_start = 1'b1;
                    end else begin
                        timer_d   = timer_q + TIMER_W'(1);
                        ber_cnt_d = cnt_upd;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                    ber_cnt_d = '0;
                    hi_ber_d  = 1'b0;
                end
            endcase
        end
        // Threshold 0 disables detection entirely.
        if (thresh_q == '0) begin
            hi_ber_d = 1'b0;
            if (state_d == ST_HI_BER) begin
                state_d = ST_COUNT;
            end
        end
    end

    // Status, statistics and config registers
    always_comb begin
        sync_d        = sync_in;
        link_good_d   = sync_q & ~hi_ber_q;
        // Set wins over a same-cycle W1C.
        sticky_hi_d   = (sticky_hi_q & ~(wr_sel[0] & bus.iCSR_WR_DATA[2])) | hi_ber_d;
        sticky_loss_d = (sticky_loss_q & ~(wr_sel[0] & bus.iCSR_WR_DATA[3])) |
                        (sync_q & ~sync_in);
        bad_cnt_d     = bad_cnt_q;
        if (wr_sel[1]) begin
            bad_cnt_d = '0;
        end else if (bad_blk && (bad_cnt_q != BAD_MAX)) begin
            bad_cnt_d = bad_cnt_q + BAD_W'(1);
        end
        evt_cnt_d     = evt_cnt_q;
        if (wr_sel[2]) begin
            evt_cnt_d = '0;
        end else if (!hi_ber_q && hi_ber_d && (evt_cnt_q != EVT_MAX)) begin
            evt_cnt_d = evt_cnt_q + EVT_W'(1);
        end
        thresh_d      = wr_sel[3] ? bus.iCSR_WR_DATA[CNT_W-1:0] : thresh_q;
`ifdef FC1_BER_WINDOW_CSR_EN
        window_d      = wr_sel[4] ? bus.iCSR_WR_DATA[TIMER_W-1:0] : window_q;
        win_act_d     = win_start ? window_q : win_act_q;
`endif
    end

    // Registered CSR read path; misses leave data untouched
    always_comb begin
        rd_mux = '0;
        case (addr_off)
            10'd0:   rd_mux = {60'd0, sticky_loss_q, sticky_hi_q, sync_q, hi_ber_q};
            10'd1:   rd_mux = {32'd0, bad_cnt_q};
            10'd2:   rd_mux = {48'd0, evt_cnt_q};
            10'd3:   rd_mux = {59'd0, thresh_q};
`ifdef FC1_BER_WINDOW_CSR_EN
            10'd4:   rd_mux = {40'd0, window_q};
`endif
            default: rd_mux = '0;
        endcase
        rd_v_d    = bus.iCSR_RD_EN & addr_hit;
        rd_data_d = rd_v_d ? rd_mux : rd_data_q;
    end

    always_ff @(posedge iCLK_FC_CORE) begin
        if (iRST_FC_CORE) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            ber_cnt_q     <= '0;
            hi_ber_q      <= 1'b0;
            sync_q        <= 1'b0;
            link_good_q   <= 1'b0;
            thresh_q      <= CNT_W'(HIBER_THRESH);
            bad_cnt_q     <= '0;
            evt_cnt_q     <= '0;
            sticky_hi_q   <= 1'b0;
            sticky_loss_q <= 1'b0;
            rd_data_q     <= '0;
            rd_v_q        <= 1'b0;
`ifdef FC1_BER_WINDOW_CSR_EN
            window_q      <= WIN_RST;
            win_act_q     <= WIN_RST;
`endif
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ber_cnt_q     <= ber_cnt_d;
            hi_ber_q      <= hi_ber_d;
            sync_q        <= sync_d;
            link_good_q   <= link_good_d;
            thresh_q      <= thresh_d;
            bad_cnt_q     <= bad_cnt_d;
            evt_cnt_q     <= evt_cnt_d;
            sticky_hi_q   <= sticky_hi_d;
            sticky_loss_q <= sticky_loss_d;
            rd_data_q     <= rd_data_d;
            rd_v_q        <= rd_v_d;
`ifdef FC1_BER_WINDOW_CSR_EN
            window_q      <= window_d;
            win_act_q     <= win_act_d;
`endif
        end
    end

    assign oHI_BER            = hi_ber_q;
    assign oLINK_GOOD         = link_good_q;
    assign bus.oCSR_RD_DATA   = rd_data_q;
    assign bus.oCSR_RD_DATA_V = rd_v_q;

endmodule

// File: tb/tb_fc1_kr_ber_mon.sv
// ---------------------------------------------------------------------------
// tb_fc1_kr_ber_mon
// Randomised plus targeted stimulus for fc1_kr_ber_mon against a behavioural
// window/threshold model. Expected pin values and CSR read data are queued at
// each clock edge and consumed by an independent monitor on the falling edge.
// Honours FC1_BER_WINDOW_CSR_EN when defined.
// ---------------------------------------------------------------------------
module tb_fc1_kr_ber_mon;
    localparam int unsigned W    = 200;
    localparam int unsigned TH   = 16;
    localparam logic [9:0]  BASE = 10'h040;
`ifdef FC1_BER_WINDOW_CSR_EN
    localparam int unsigned NREG = 5;
`else
    localparam int unsigned NREG = 4;
`endif

    logic clk = 1'b0;
    logic rst;
    logic hi_ber, link_good;

    fc1_kr_ber_mon_if bus ();

    fc1_kr_ber_mon #(
        .WINDOW_CYCLES (W),
        .HIBER_THRESH  (TH),
        .CSR_BASE      (BASE)
    ) dut (
        .iCLK_FC_CORE (clk),
        .iRST_FC_CORE (rst),
        .bus          (bus),
        .oHI_BER      (hi_ber),
        .oLINK_GOOD   (link_good)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  pin_q[$];
    logic [63:0] rd_q[$];
    int          rd_off_q[$];

    // Behavioural model state (values as seen after the most recent edge)
    bit      m_active, m_latched, m_hi, m_sync, m_lg;
    bit      m_st_hi, m_st_loss;
    int      m_pos, m_cnt, m_thr, m_evt;
    longint  m_bad;
    int      m_win_reg, m_win_act;

    function automatic int m_lim();
        return (m_win_act == 0) ? 1 : m_win_act;
    endfunction

    function automatic logic [63:0] model_read(input int unsigned off);
        logic [63:0] r;
        r = '0;
        case (off)
            0: r = {60'd0, m_st_loss, m_st_hi, m_sync, m_hi};
            1: r = 64'(m_bad);
            2: r = 64'(m_evt);
            3: r = 64'(m_thr);
            4: r = 64'(m_win_reg);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_active = 0; m_latched = 0; m_hi = 0; m_sync = 0; m_lg = 0;
        m_st_hi = 0; m_st_loss = 0;
        m_pos = 0; m_cnt = 0; m_thr = TH; m_evt = 0; m_bad = 0;
        m_win_reg = W; m_win_act = W;
    endtask

    task automatic model_update(input bit sync, input bit bad, input bit wr,
                                input int unsigned off, input logic [63:0] wd);
        bit old_hi, old_sync, expire, w;
        old_hi   = m_hi;
        old_sync = m_sync;
        w        = wr && (off < NREG);
        if (!sync) begin
            m_active = 0; m_latched = 0; m_hi = 0; m_pos = 0; m_cnt = 0;
        end else if (!m_active) begin
            m_active = 1; m_pos = 0; m_cnt = 0; m_win_act = m_win_reg;
        end else begin
            expire = (m_pos == m_lim() - 1);
            m_cnt  = (m_cnt + int'(bad) > 31) ? 31 : m_cnt + int'(bad);
            if (m_latched) begin
                if (expire) m_latched = 0;
            end else if (m_thr != 0 && m_cnt >= m_thr) begin
                m_hi = 1; m_latched = 1;
            end else if (expire) begin
                m_hi = 0;
            end
            if (expire) begin
                m_pos = 0; m_cnt = 0; m_win_act = m_win_reg;
            end else begin
                m_pos++;
            end
        end
        if (m_thr == 0) begin
            m_hi = 0; m_latched = 0;
        end
        m_lg      = old_sync & ~old_hi;
        m_sync    = sync;
        m_st_hi   = (m_st_hi & !(w && off == 0 && wd[2])) | m_hi;
        m_st_loss = (m_st_loss & !(w && off == 0 && wd[3])) | (old_sync & !sync);
        if (w && off == 1) m_bad = 0;
        else if (bad && m_bad < 64'hFFFF_FFFF) m_bad++;
        if (w && off == 2) m_evt = 0;
        else if (!old_hi && m_hi && m_evt < 65535) m_evt++;
        if (w && off == 3) m_thr = int'(wd[4:0]);
        if (w && off == 4) m_win_reg = int'(wd[23:0]);
    endtask

    // One clock of stimulus; expectations are queued at the edge.
    task automatic step(input bit r, input bit sync, input logic [1:0] sh, input bit en,
                        input bit wr, input bit rd, input int unsigned off,
                        input logic [63:0] wd);
        bit bad, push_rd;
        logic [63:0] exp_rd;
        rst                      = r;
        bus.iPCS_DOUT_BLOCK_SYNC = sync;
        bus.iPCS_DOUT_SH         = sh;
        bus.iPCS_DOUT_EN         = en;
        bus.iCSR_WR_EN           = wr;
        bus.iCSR_RD_EN           = rd;
        bus.iCSR_ADDR            = BASE + 10'(off);
        bus.iCSR_WR_DATA         = wd;
        bad     = en && (sh == 2'b00 || sh == 2'b11);
        push_rd = !r && rd && (off < NREG);
        exp_rd  = push_rd ? model_read(off) : 64'd0;
        if (r) model_reset();
        else   model_update(sync, bad, wr, off, wd);
        @(posedge clk);
        pin_q.push_back({m_hi, m_lg});
        if (push_rd) begin
            rd_q.push_back(exp_rd);
            rd_off_q.push_back(int'(off));
        end
        #1;
    endtask

    function automatic logic [1:0] good_sh();
        return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic clean(input bit sync);
        step(0, sync, good_sh(), 1'b1, 0, 0, 0, 64'd0);
    endtask

    task automatic bad1();
        step(0, 1, 2'b00, 1'b1, 0, 0, 0, 64'd0);
    endtask

    task automatic csr_rd(input bit sync, input int unsigned off);
        step(0, sync, good_sh(), 1'b1, 0, 1, off, 64'd0);
    endtask

    task automatic csr_wr(input bit sync, input int unsigned off, input logic [63:0] wd);
        step(0, sync, good_sh(), 1'b1, 1, 0, off, wd);
    endtask

    // Clean blocks until the model's window position reaches p (bounded).
    task automatic wait_pos(input int p);
        for (int k = 0; k < 4 * int'(W) && m_pos != p; k++) clean(1);
    endtask

    task automatic rand_cycle(input int pct, input bit r);
        bit s, en, b, wr, rd;
        logic [1:0] sh;
        int unsigned off;
        logic [63:0] wd;
        s   = ($urandom_range(0, 399) != 0);
        en  = ($urandom_range(0, 3) != 0);
        b   = ($urandom_range(0, 99) < pct);
        sh  = b ? (($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11) : good_sh();
        wr  = ($urandom_range(0, 59) == 0);
        rd  = ($urandom_range(0, 5) == 0);
        off = $urandom_range(0, 5);
        wd  = {$urandom, $urandom};
        if (off == 3) wd = 64'($urandom_range(0, 31));
        if (off == 4) wd = 64'($urandom_range(0, 40));
        step(r, s, sh, en, wr, rd, off, wd);
    endtask

    // Monitor: compares pins every cycle and read data whenever expected or presented
    logic [1:0]  mon_pin;
    logic [63:0] mon_rd;
    int          mon_off;
    initial begin
        forever begin
            @(negedge clk);
            if (pin_q.size() > 0) begin
                mon_pin = pin_q.pop_front();
                checks++;
                if (hi_ber !== mon_pin[1]) begin
                    failures++;
                    $display("FAIL hi_ber t=%0t got=%b exp=%b", $time, hi_ber, mon_pin[1]);
                end
                checks++;
                if (link_good !== mon_pin[0]) begin
                    failures++;
                    $display("FAIL link_good t=%0t got=%b exp=%b", $time, link_good, mon_pin[0]);
                end
            end
            if (bus.oCSR_RD_DATA_V === 1'b1) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_v_unexpected t=%0t got=1 exp=0", $time);
                end else begin
                    mon_rd  = rd_q.pop_front();
                    mon_off = rd_off_q.pop_front();
                    if (bus.oCSR_RD_DATA !== mon_rd) begin
                        failures++;
                        $display("FAIL csr_rd off=%0d t=%0t got=%h exp=%h",
                                 mon_off, $time, bus.oCSR_RD_DATA, mon_rd);
                    end
                end
            end else if (rd_q.size() > 0) begin
                checks++;
                failures++;
                mon_rd  = rd_q.pop_front();
                mon_off = rd_off_q.pop_front();
                $display("FAIL rd_v_missing off=%0d t=%0t got=%b exp=1",
                         mon_off, $time, bus.oCSR_RD_DATA_V);
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) step(1, 0, 2'b01, 1'b0, 0, 0, 0, 64'd0);
        csr_rd(0, 0);
        csr_rd(0, 3);

        // Clean traffic for three windows, random EN, periodic reads
        for (int i = 0; i < 3 * int'(W) + 5; i++) begin
            step(0, 1, good_sh(), ($urandom_range(0, 1) != 0), 0, (i % 37) == 0,
                 $urandom_range(0, 3), 64'd0);
        end
        csr_rd(1, 1);

        // 16 bad blocks in one window, then clean windows
        wait_pos(5);
        repeat (16) bad1();
        csr_rd(1, 0);
        csr_rd(1, 2);
        repeat (2 * W + 10) clean(1);
        csr_rd(1, 0);

        // 15 bad, then the 16th on the expiry cycle of the same window
        wait_pos(10);
        repeat (15) bad1();
        wait_pos(m_lim() - 1);
        bad1();
        repeat (3) clean(1);
        repeat (2 * W + 5) clean(1);

        // 15 bad at the end of window A, 1 at the start of window B
        wait_pos(m_lim() - 20);
        repeat (15) bad1();
        wait_pos(0);
        bad1();
        repeat (W + 5) clean(1);

        // Enter HI_BER, drop block_sync, then W1C the sticky bits
        wait_pos(5);
        repeat (16) bad1();
        repeat (3) clean(1);
        repeat (3) clean(0);
        csr_rd(0, 0);
        csr_wr(0, 0, 64'hC);
        csr_rd(0, 0);
        repeat (4) clean(1);

        // Detection disabled: threshold 0 with 100 bad blocks
        csr_wr(1, 1, 64'd0);
        csr_wr(1, 3, 64'd0);
        for (int i = 0; i < 100; i++) begin
            bad1();
            if (i % 3 == 0) clean(1);
        end
        csr_rd(1, 1);
        csr_rd(1, 0);
        step(0, 1, 2'b11, 1'b1, 1, 0, 1, 64'hFFFF);
        csr_rd(1, 1);
        csr_wr(1, 3, 64'(TH));
        csr_rd(1, 3);

`ifdef FC1_BER_WINDOW_CSR_EN
        // Short window: 16 bad blocks over 20 cycles never fill one window
        csr_wr(1, 4, 64'd10);
        csr_rd(1, 4);
        for (int k = 0; k < 4 * int'(W) && !(m_win_act == 10 && m_pos == 0); k++) clean(1);
        for (int i = 0; i < 20; i++) begin
            if (i % 5 == 4) clean(1); else bad1();
        end
        csr_rd(1, 0);
        csr_wr(1, 4, 64'd0);
        repeat (30) clean(1);
        csr_wr(1, 4, 64'(W));
`else
        // Offset 4 is undecoded: no read response, writes ignored
        csr_rd(1, 4);
        csr_wr(1, 4, 64'd5);
        csr_rd(1, 3);
`endif
        repeat (5) clean(1);

        // Randomised mix including a mid-run reset with an outstanding read
        for (int seg = 0; seg < 12; seg++) begin
            int pct;
            pct = $urandom_range(0, 14);
            for (int i = 0; i < 300; i++) rand_cycle(pct, (seg == 6) && (i == 150));
        end
        for (int off = 0; off < int'(NREG); off++) csr_rd(1, off);

        repeat (4) clean(1);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
